// File: rtl/updown_counter.sv
// Parametrised up/down counter with wrap/saturate bounds, terminal-count pulse,
// compare match and sticky overflow. Optional prescaler: define COUNTER_PRESCALE_EN.
module updown_counter #(
    parameter int WIDTH      = 8,
    parameter int MOD_MAX    = 2**WIDTH-1,
    parameter int PRESCALE_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data,
    input  logic             load,
    input  logic             enable,
    input  logic             up,
    input  logic             saturate,
    input  logic [WIDTH-1:0] cmp_val,
    input  logic             clr_ovf,
`ifdef COUNTER_PRESCALE_EN
    input  logic [PRESCALE_W-1:0] prescale,
`endif
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             match,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MOD_MAX);

    if (WIDTH < 2 || MOD_MAX < 0 || MOD_MAX > 2**WIDTH-1 || PRESCALE_W < 1) begin : g_bad_params
        $error("updown_counter: illegal WIDTH/MOD_MAX/PRESCALE_W combination");
    end

    logic             step;
    logic             at_bound;
    logic [WIDTH-1:0] q_step;
    logic [WIDTH-1:0] load_val;

`ifdef COUNTER_PRESCALE_EN
    logic [PRESCALE_W-1:0] div;
    logic                  div_hit;

    // >= rather than == so a prescale lowered below the current divider steps at once.
    assign div_hit = (div >= prescale);
    assign step    = enable & ~load & div_hit;

    always_ff @(posedge clk) begin
        if (reset || load) begin
            div <= '0;
        end else if (enable) begin
            div <= div_hit ? '0 : div + PRESCALE_W'(1);
        end
    end
`else
    assign step = enable & ~load;
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        at_bound = 1'b0;
        q_step   = q;
        if (up) begin
            at_bound = (q == MAX_Q);
            q_step   = at_bound ? (saturate ? MAX_Q : '0) : q + WIDTH'(1);
        end else begin
            at_bound = (q == '0);
            q_step   = at_bound ? (saturate ? '0 : MAX_Q) : q - WIDTH'(1);
        end
    end

    // Loads are clamped so q can never leave 0..MOD_MAX.
    assign load_val = (data > MAX_Q) ? MAX_Q : data;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            q   <= '0;
            tc  <= 1'b0;
            ovf <= 1'b0;
        end else begin
            tc <= step & at_bound;
            if (load) begin
                q <= load_val;
            end else if (step) begin
                q <= q_step;
            end
            // A bound event in the same cycle as clr_ovf keeps the flag set.
            if (step && at_bound) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

    assign match = (q == cmp_val);

endmodule

// File: tb/tb_updown_counter.sv
// Scoreboard bench for updown_counter (WIDTH=8, MOD_MAX=9): a driver pushes model
// predictions into a queue, a monitor pops and compares once per cycle.
module tb_updown_counter;

    localparam int WIDTH   = 8;
    localparam int MOD_MAX = 9;
    localparam int RANGE   = MOD_MAX + 1;

    logic             clk = 1'b0;
    logic             reset, load, enable, up, saturate, clr_ovf;
    logic [WIDTH-1:0] data, cmp_val;
    logic [3:0]       prescale;
    logic [WIDTH-1:0] q;
    logic             tc, match, ovf;

    always #5 clk = ~clk;

    updown_counter #(.WIDTH(WIDTH), .MOD_MAX(MOD_MAX), .PRESCALE_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .data     (data),
        .load     (load),
        .enable   (enable),
        .up       (up),
        .saturate (saturate),
        .cmp_val  (cmp_val),
        .clr_ovf  (clr_ovf),
`ifdef COUNTER_PRESCALE_EN
        .prescale (prescale),
`endif
        .q        (q),
        .tc       (tc),
        .match    (match),
        .ovf      (ovf)
    );

    typedef struct {
        int q;
        bit tc;
        bit ovf;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;

    // Reference model state: count, sticky flag, enabled cycles since last step.
    int   m_q    = 0;
    bit   m_ovf  = 1'b0;
    int   m_wait = 0;

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual == expected) passed++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    endtask

    // Drive one cycle of inputs, predict the state after the next edge, then advance.
    task automatic cycle(input bit r, input bit ld, input int d, input bit en, input bit u,
                         input bit s, input int cv, input bit co);
        exp_t e;
        bit   stepped;
        bit   bound;
        int   t;
        reset = r; load = ld; data = WIDTH'(d); enable = en; up = u;
        saturate = s; cmp_val = WIDTH'(cv); clr_ovf = co;
        stepped = 1'b0;
        bound   = 1'b0;
        if (r) begin
            m_q = 0; m_ovf = 1'b0; m_wait = 0;
        end else begin
            if (ld) begin
                m_q    = (d > MOD_MAX) ? MOD_MAX : d;
                m_wait = 0;
            end else if (en) begin
`ifdef COUNTER_PRESCALE_EN
                if (m_wait >= int'(prescale)) begin
                    stepped = 1'b1;
                    m_wait  = 0;
                end else begin
                    m_wait++;
                end
`else
                stepped = 1'b1;
`endif
            end
            if (stepped) begin
                t     = m_q + (u ? 1 : -1);
                bound = (t < 0) || (t > MOD_MAX);
                if (!bound)  m_q = t;
                else if (!s) m_q = (t + RANGE) % RANGE;
            end
            if (bound)   m_ovf = 1'b1;
            else if (co) m_ovf = 1'b0;
        end
        e.q = m_q; e.tc = bound; e.ovf = m_ovf;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            if (sb.size() == 0) begin
                total++;
                $display("FAIL scoreboard_empty: DUT cycle with no prediction, got q=%0d, expected a queued entry", q);
            end else begin
                e = sb.pop_front();
                check("q", int'(q), e.q);
                check("tc", int'(tc), int'(e.tc));
                check("ovf", int'(ovf), int'(e.ovf));
                check("match", int'(match), int'(e.q == int'(cmp_val)));
            end
        end
    end

    initial begin : driver
        prescale = 4'd0;
        // reset, then wrap up through the bound
        cycle(1, 0, 0, 0, 1, 0, 0, 0);
        cycle(1, 1, 7, 1, 1, 0, 0, 0);
        for (int i = 0; i < 12; i++) cycle(0, 0, 0, 1, 1, 0, 0, 0);
        // saturate down from 2, then clear ovf
        cycle(0, 1, 2, 0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 0, 1);
        cycle(0, 0, 0, 0, 0, 1, 0, 0);
        // load clamp beats step; reset beats load
        cycle(0, 1, 200, 1, 1, 0, 9, 0);
        cycle(1, 1, 5, 1, 1, 0, 0, 0);
        // clr_ovf coinciding with a bound event, then alone
        cycle(0, 1, 9, 0, 1, 0, 0, 0);
        cycle(0, 0, 0, 1, 1, 0, 0, 1);
        cycle(0, 0, 0, 0, 1, 0, 0, 1);
        cycle(0, 0, 0, 0, 1, 0, 0, 0);
        // compare match with a direction flip at 6
        cycle(0, 1, 3, 0, 1, 0, 5, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 1, 0, 5, 0);
        for (int i = 0; i < 2; i++) cycle(0, 0, 0, 1, 0, 0, 5, 0);
        cycle(0, 0, 0, 0, 0, 0, 12, 0);
`ifdef COUNTER_PRESCALE_EN
        // prescale=2: steps every third enabled cycle; a load restarts the spacing
        cycle(0, 1, 0, 0, 1, 0, 0, 0);
        prescale = 4'd2;
        for (int i = 0; i < 9; i++) cycle(0, 0, 0, 1, 1, 0, 3, 0);
        cycle(0, 0, 0, 1, 1, 0, 0, 0);
        cycle(0, 1, 1, 1, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, i != 2, 1, 0, 0, 0);
        prescale = 4'd0;
`endif
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
`ifdef COUNTER_PRESCALE_EN
            if ($urandom_range(0, 15) == 0) prescale = 4'($urandom_range(0, 4));
`endif
            cycle($urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 255),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 15), $urandom_range(0, 7) == 0);
        end
        #4;
        check("drain", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/updown_counter.md
Name: updown_counter

Overview:
Parametrised successor to the team's 8-bit loadable up-counter. It adds:
- generic width and modulus;
- up/down direction;
- wrap or saturate mode at the range bounds;
- terminal-count pulse, compare match and a sticky overflow flag.

Used as the general-purpose event, timer and decade counter in datapath and timing blocks.

Parameters:
WIDTH, 8, counter width in bits (>=2)
MOD_MAX, 2**WIDTH-1, highest legal count; range is 0..MOD_MAX; must be <= 2**WIDTH-1
PRESCALE_W, 4, prescale field width; used only when COUNTER_PRESCALE_EN is defined

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
data  in  WIDTH  value for load
load  in  1  load data into q
enable  in  1  count-step request
up  in  1  direction: 1=increment, 0=decrement
saturate  in  1  bound mode: 1=saturate at bound, 0=wrap modulo MOD_MAX+1
cmp_val  in  WIDTH  compare value
clr_ovf  in  1  clear sticky overflow flag
q  out  WIDTH  current count (registered)
tc  out  1  terminal-count pulse (registered, one cycle)
match  out  1  q == cmp_val (combinational from q)
ovf  out  1  sticky bound-hit flag (registered)

Behaviour:
- All state updates on the rising edge of clk; reset is sampled synchronously.
- Reset: q=0, tc=0, ovf=0, internal prescale divider=0. Reset overrides all other inputs.
- Priority: reset > load > step.
- Load: q <= min(data, MOD_MAX); tc=0 that cycle; ovf unchanged; prescale divider cleared.
- Step: occurs when enable=1 and load=0 (gated by prescaler if enabled); one-cycle latency to q.
- Up step, q<MOD_MAX: q+1.
- Up step, q==MOD_MAX: wrap mode gives q=0; saturate mode holds q=MOD_MAX.
- Down step, q>0: q-1.
- Down step, q==0: wrap mode gives q=MOD_MAX; saturate mode holds q=0.
- Bound event: a step taken at a bound (up at MOD_MAX, or down at 0), in either mode.
- A bound event sets tc=1 for exactly the next cycle and sets ovf=1.
- tc is 0 in every cycle not following a bound event. Repeated saturated steps produce tc every step.
- ovf is sticky until clr_ovf=1 or reset. If clr_ovf and a bound event occur in the same cycle, set wins (ovf=1).
- Load does not clear ovf.
- enable=0 with load=0: q holds, tc=0.
- up and saturate are sampled each cycle. A direction change takes effect on the same step.
- match is purely combinational on q and cmp_val. cmp_val values above MOD_MAX simply never match.
- Arithmetic is unsigned WIDTH-bit. No out-of-range q is ever produced, including when MOD_MAX is not 2**WIDTH-1.

Optional Feature:
Macro COUNTER_PRESCALE_EN.
- Defined:
  - Adds input port prescale [PRESCALE_W-1:0] and an internal PRESCALE_W-bit divider.
  - While enable=1 and load=0, the divider increments each cycle.
  - When divider == prescale, a step is taken and the divider returns to 0. prescale=0 therefore steps every enabled cycle; prescale=N steps every N+1 enabled cycles.
  - enable=0 holds the divider.
  - Load or reset clears the divider.
  - If prescale changes while divider > prescale, the next step is taken on the following enabled cycle and the divider then restarts from 0.
- Not defined: the prescale port and divider are absent; every enabled, non-load cycle is a step.

Test Plan:
1. WIDTH=8, MOD_MAX=9, wrap, up: reset, enable for 12 cycles -> q=0..9,0,1,2; tc=1 only the cycle q becomes 0; ovf=1 afterwards.
2. MOD_MAX=9, saturate, down: load data=2, enable 4 cycles -> q=2,1,0,0,0; tc pulses on each of the last two steps; ovf=1; clr_ovf=1 -> ovf=0.
3. Load clamp and priority: load=1, enable=1, data=200, MOD_MAX=9 -> q=9 next cycle, no step, tc=0. Then reset=1 with load=1 -> q=0.
4. Simultaneous clr_ovf and bound event: wrap at q=9 up with clr_ovf=1 -> ovf stays 1. Next cycle clr_ovf=1 alone -> ovf=0.
5. Compare and direction flip: WIDTH=8, MOD_MAX=255, cmp_val=5; count up from 3, flip up=0 at q=6 -> match high only while q=5 (twice); no tc.
6. COUNTER_PRESCALE_EN, prescale=2, enable held 9 cycles from q=0 -> q steps on cycles 3, 6 and 9, ending at q=3. Load mid-sequence restarts the 3-cycle spacing.
